triangle_bitmap: RTL and testbench

Downstream stage of the triangle rasterizer. It consumes the rasterizer's point stream (`po`/`xo`/`yo`) into an 8x8 one-bit bitmap and counts distinct pixels. When the rasterizer's `busy` falls, it dumps the bitmap row by row over a valid/ready port, then clears itself for the next triangle. It also gates the upstream `nt` strobe so a new triangle cannot start while a dump is in progress.

---
 rtl/triangle_bitmap_pkg.sv | 14 +
 rtl/bitmap8x8.sv | 33 +++
 rtl/triangle_bitmap.sv | 115 +++++++++++
 tb/tb_triangle_bitmap.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/triangle_bitmap_pkg.sv
`default_nettype none
// ==== triangle_bitmap_pkg : shared sizes and state codes for the bitmap stage ====
// ==== rev 1.0 ====
package triangle_bitmap_pkg;
  localparam int GRID    = 8;
  localparam int COORD_W = 3;
  localparam int CNT_W   = 7;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_DUMP  = 2'd2;
endpackage
`default_nettype wire

// File: rtl/bitmap8x8.sv
`default_nettype none
// ==== bitmap8x8 : 8x8 one-bit store with set, clear-all, old-bit and row read ====
// ==== rev 1.0 ====
module bitmap8x8
  import triangle_bitmap_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               set_en,
  input  logic [COORD_W-1:0] set_x,
  input  logic [COORD_W-1:0] set_y,
  input  logic               clear_all,
  output logic               old_bit,
  input  logic [COORD_W-1:0] rd_y,
  output logic [GRID-1:0]    rd_row
);
  // rows[y][x] holds pixel (x,y)
  logic [GRID-1:0] rows [GRID];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < GRID; i++) rows[i] <= '0;
    end else if (clear_all) begin
      for (int i = 0; i < GRID; i++) rows[i] <= '0;
    end else if (set_en) begin
      rows[set_y][set_x] <= 1'b1;
    end
  end

  assign old_bit = rows[set_y][set_x];
  assign rd_row  = rows[rd_y];
endmodule
`default_nettype wire

// File: rtl/triangle_bitmap.sv
`default_nettype none
// ==== triangle_bitmap : collects rasterizer points into an 8x8 bitmap, dumps rows on busy fall ====
// ==== rev 1.0 ====
module triangle_bitmap
  import triangle_bitmap_pkg::*;
#(
  parameter int X_LSB = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               po,
  input  logic [COORD_W-1:0] xo,
  input  logic [COORD_W-1:0] yo,
  input  logic               busy_in,
  output logic               nt_ok,
  output logic               row_vld,
  input  logic               row_rdy,
  output logic [COORD_W-1:0] row_y,
  output logic [GRID-1:0]    row_bits,
  output logic [CNT_W-1:0]   cnt,
  output logic               done,
  output logic               overrun
);
  state_t          state;
  logic            busy_q;
  logic            busy_rise;
  logic            busy_fall;
  logic            accept;
  logic            last_row;
  logic            set_en;
  logic            old_bit;
  logic            new_pixel;
  logic [GRID-1:0] raw_row;

  assign busy_rise = busy_in & ~busy_q;
  assign busy_fall = busy_q & ~busy_in;
  assign accept    = row_vld & row_rdy;
  assign last_row  = accept & (row_y == COORD_W'(GRID - 1));
  // Points arriving during a dump must not disturb the image being read out
  assign set_en    = po & (state != ST_DUMP);
  assign new_pixel = set_en & ~old_bit;

  bitmap8x8 u_bitmap (
    .clk       (clk),
    .reset     (reset),
    .set_en    (set_en),
    .set_x     (xo),
    .set_y     (yo),
    .clear_all (last_row),
    .old_bit   (old_bit),
    .rd_y      (row_y),
    .rd_row    (raw_row)
  );

  generate
    if (X_LSB != 0) begin : g_lsb
      assign row_bits = raw_row;
    end else begin : g_msb
      for (genvar i = 0; i < GRID; i++) begin : g_rev
        assign row_bits[i] = raw_row[GRID-1-i];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      busy_q  <= 1'b0;
      nt_ok   <= 1'b1;
      row_vld <= 1'b0;
      row_y   <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      busy_q <= busy_in;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (busy_rise | po) begin
            state <= ST_ACCUM;
            nt_ok <= 1'b0;
            cnt   <= CNT_W'(new_pixel);
          end
        end
        ST_ACCUM: begin
          if (new_pixel) cnt <= cnt + CNT_W'(1);
          if (busy_fall) begin
            state   <= ST_DUMP;
            row_vld <= 1'b1;
            row_y   <= '0;
          end
        end
        ST_DUMP: begin
          if (po) overrun <= 1'b1;
          if (last_row) begin
            state   <= ST_IDLE;
            row_vld <= 1'b0;
            nt_ok   <= 1'b1;
            done    <= 1'b1;
            row_y   <= '0;
          end else if (accept) begin
            row_y <= row_y + COORD_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          nt_ok   <= 1'b1;
          row_vld <= 1'b0;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_triangle_bitmap.sv
`default_nettype none
// ==== tb_triangle_bitmap : directed frames checked against a point-set model of the bitmap stage ====
// ==== rev 1.0 ====
module tb_triangle_bitmap;
  localparam int X_LSB = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       po = 1'b0;
  logic [2:0] xo = '0;
  logic [2:0] yo = '0;
  logic       busy_in = 1'b0;
  logic       row_rdy = 1'b0;
  logic       nt_ok, row_vld, done, overrun;
  logic [2:0] row_y;
  logic [7:0] row_bits;
  logic [6:0] cnt;

  triangle_bitmap #(.X_LSB(X_LSB)) dut (
    .clk(clk), .reset(reset), .po(po), .xo(xo), .yo(yo), .busy_in(busy_in),
    .nt_ok(nt_ok), .row_vld(row_vld), .row_rdy(row_rdy), .row_y(row_y),
    .row_bits(row_bits), .cnt(cnt), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the frame is the set of distinct points accepted since the last frame start.
  bit frame [64];
  int phase = 0;     // 0 idle, 1 collecting, 2 reading out
  int m_row = 0;
  bit m_done = 1'b0;
  bit m_over = 1'b0;
  bit prev_busy = 1'b0;

  function automatic logic [7:0] exp_row(int y);
    logic [7:0] r = '0;
    for (int x = 0; x < 8; x++)
      if (frame[y*8+x]) r[X_LSB != 0 ? x : 7-x] = 1'b1;
    return r;
  endfunction

  function automatic int pop();
    int n = 0;
    for (int i = 0; i < 64; i++) n += int'(frame[i]);
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) frame[i] = 1'b0;
      phase = 0; m_row = 0; m_done = 1'b0; m_over = 1'b0; prev_busy = 1'b0;
    end else begin
      int was;
      was = phase;
      m_done = 1'b0;
      if (was == 0 && ((busy_in && !prev_busy) || po)) begin
        for (int i = 0; i < 64; i++) frame[i] = 1'b0;
        if (po) frame[int'(yo)*8+int'(xo)] = 1'b1;
        phase = 1;
      end else if (was == 1) begin
        if (po) frame[int'(yo)*8+int'(xo)] = 1'b1;
        if (prev_busy && !busy_in) begin phase = 2; m_row = 0; end
      end else if (was == 2) begin
        if (po) m_over = 1'b1;
        if (row_rdy) begin
          if (m_row == 7) begin phase = 0; m_row = 0; m_done = 1'b1; end
          else m_row++;
        end
      end
      prev_busy = busy_in;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("nt_ok", nt_ok, phase == 0);
      chk("row_vld", row_vld, phase == 2);
      chk("row_y", row_y, m_row);
      chk("row_bits", row_bits, phase == 0 ? 8'h00 : exp_row(m_row));
      chk("cnt", cnt, pop());
      chk("done", done, m_done);
      chk("overrun", overrun, m_over);
    end
  end

  // Capture what the consumer actually accepts.
  logic [7:0] cap [8];
  int acc_q [$];
  int done_cnt = 0;

  always @(negedge clk) begin
    if (reset && row_vld && row_rdy) begin
      cap[row_y] = row_bits;
      acc_q.push_back(int'(row_y));
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic point(input int x, input int y);
    po = 1'b1; xo = 3'(x); yo = 3'(y);
    tick();
    po = 1'b0;
  endtask

  task automatic start_frame();
    busy_in = 1'b1;
    tick();
    chk("nt_ok_accum", nt_ok, 1'b0);
  endtask

  task automatic end_frame();
    busy_in = 1'b0;
    tick();
    chk("dump_entry_vld", row_vld, 1'b1);
  endtask

  task automatic dump_run(input int stall_at, input int stall_n, input logic [7:0] stall_exp,
                          input int po_at, input int rst_at);
    int stalled = 0;
    bit po_done = 1'b0;
    bit finished = 1'b0;
    for (int i = 0; i < 8; i++) cap[i] = 'x;
    acc_q.delete();
    done_cnt = 0;
    for (int c = 0; c < 200 && !finished; c++) begin
      if (int'(row_y) == rst_at) begin
        row_rdy = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_nt_ok", nt_ok, 1'b1);
        chk("rst_row_vld", row_vld, 1'b0);
        chk("rst_row_y", row_y, 3'd0);
        chk("rst_row_bits", row_bits, 8'h00);
        chk("rst_cnt", cnt, 7'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        return;
      end
      if (int'(row_y) == stall_at && stalled < stall_n) begin
        row_rdy = 1'b0;
        chk("stall_row_y", row_y, 3'(stall_at));
        chk("stall_row_bits", row_bits, stall_exp);
        stalled++;
      end else begin
        row_rdy = 1'b1;
      end
      if (int'(row_y) == po_at && !po_done) begin
        po = 1'b1; xo = 3'd7; yo = 3'd7; po_done = 1'b1;
      end else begin
        po = 1'b0;
      end
      tick();
      if (done) finished = 1'b1;
    end
    po = 1'b0;
    row_rdy = 1'b0;
    chk("dump_finished", finished, 1'b1);
    tick();
    chk("done_pulses", done_cnt, 1);
    chk("nt_ok_after", nt_ok, 1'b1);
  endtask

  task automatic chk_rows(input logic [63:0] exp);
    for (int i = 0; i < 8; i++) chk($sformatf("row%0d", i), cap[i], exp[i*8 +: 8]);
  endtask

  initial begin
    logic [63:0] rows;
    tick(); tick();
    reset = 1'b1;
    chk("reset_nt_ok", nt_ok, 1'b1);
    chk("reset_row_vld", row_vld, 1'b0);
    chk("reset_row_y", row_y, 3'd0);
    chk("reset_row_bits", row_bits, 8'h00);
    chk("reset_cnt", cnt, 7'd0);
    chk("reset_done", done, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    run = 1'b1;
    tick();

    // Basic frame with a 5-cycle stall at row 3
    start_frame();
    point(1, 1);
    chk("cnt_latency", cnt, 7'd1);
    point(1, 2); point(2, 2); point(1, 3); point(2, 3); point(3, 3);
    end_frame();
    chk("basic_cnt", cnt, 7'd6);
    dump_run(3, 5, 8'h0E, -1, -1);
    rows = 64'h00000000_0E060200;
    chk_rows(rows);
    chk("acc_len", acc_q.size(), 8);
    for (int i = 0; i < acc_q.size(); i++) chk("acc_order", acc_q[i], i);
    chk("basic_cnt_hold", cnt, 7'd6);

    // Duplicates
    start_frame();
    point(4, 5); point(4, 5); point(4, 5); point(0, 0);
    end_frame();
    dump_run(-1, 0, 8'h00, -1, -1);
    chk("dup_cnt", cnt, 7'd2);
    chk("dup_row5", cap[5], 8'h10);
    chk("dup_row0", cap[0], 8'h01);

    // Overrun during readout
    start_frame();
    point(1, 0);
    end_frame();
    dump_run(-1, 0, 8'h00, 2, -1);
    chk("ovr_flag", overrun, 1'b1);
    chk("ovr_row7", cap[7], 8'h00);
    chk("ovr_row0", cap[0], 8'h02);

    // Busy pulse with no points: empty bitmap, zero rows
    start_frame();
    end_frame();
    dump_run(-1, 0, 8'h00, -1, -1);
    chk_rows(64'h0);
    chk("empty_cnt", cnt, 7'd0);
    chk("ovr_sticky", overrun, 1'b1);

    // Point in the same cycle busy falls
    start_frame();
    point(3, 1);
    busy_in = 1'b0; po = 1'b1; xo = 3'd2; yo = 3'd6;
    tick();
    po = 1'b0;
    dump_run(-1, 0, 8'h00, -1, -1);
    chk("edge_row6", cap[6], 8'h04);
    chk("edge_row1", cap[1], 8'h08);
    chk("edge_cnt", cnt, 7'd2);

    // Reset mid-dump, then a single-point frame
    start_frame();
    point(6, 6); point(0, 5);
    end_frame();
    dump_run(-1, 0, 8'h00, -1, 4);
    tick();
    reset = 1'b1;
    tick();
    start_frame();
    point(5, 0);
    end_frame();
    dump_run(-1, 0, 8'h00, -1, -1);
    chk_rows(64'h00000000_00000020);
    chk("single_cnt", cnt, 7'd1);

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
